// File: rtl/tspp_fetch_unit.sv
// Instruction-fetch stage for the two-stage pipeline.
// Owns the PC, drives the instruction-memory request and fills the IF/EX latch.
// A redirect that arrives while memory is busy is parked in tgt_q. The old
// address is held until the access completes, and that access's data is thrown away.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   RUN    | normal fetch, PC advances/redirects under hazard-unit control
//   DRAIN  | redirect pending, waiting for the in-flight access to finish
//   HALTED | fetch stopped, iren low; leaves only through reset
module tspp_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0200,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        pc_en,
  input  logic        npc_sel,
  input  logic        if_ex_stall,
  input  logic        if_ex_flush,
  input  logic        halt,
  input  logic [31:0] redirect_addr,
  input  logic        imem_busy,
  input  logic [31:0] imem_rdata,
  output logic        iren,
  output logic [31:0] iaddr,
  output logic        i_ram_busy,
  output logic        ifex_valid,
  output logic [31:0] ifex_instr,
  output logic [31:0] ifex_pc,
  output logic [31:0] ifex_pc4
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] tgt_q;
  logic        ifex_valid_q;
  logic [31:0] ifex_instr_q;
  logic [31:0] ifex_pc_q;
  logic [31:0] ifex_pc4_q;

  logic [31:0] pc_plus4_d;
  logic [31:0] redir_d;
  logic        take_redir_d;
  logic        load_ok_d;

  // Next-address helpers and the "this cycle's word is usable" qualifier.
  always_comb begin
    pc_plus4_d   = pc_q + 32'd4;
    redir_d      = {redirect_addr[31:2], 2'b00};
    take_redir_d = pc_en & npc_sel;
    load_ok_d    = (state_q == RUN) & ~imem_busy & ~halt;
  end

  assign iaddr      = pc_q;
  assign iren       = (state_q != HALTED);
  assign i_ram_busy = iren & imem_busy;

  assign ifex_valid = ifex_valid_q;
  assign ifex_instr = ifex_instr_q;
  assign ifex_pc    = ifex_pc_q;
  assign ifex_pc4   = ifex_pc4_q;

  // Fetch FSM: PC update, redirect parking and halt handling.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      tgt_q   <= 32'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (halt && !imem_busy) begin
            state_q <= HALTED;
          end else if (pc_en) begin
            if (!npc_sel) begin
              // An increment while busy is a hazard-unit protocol error; it still increments.
              pc_q <= pc_plus4_d;
            end else if (!imem_busy) begin
              pc_q <= redir_d;
            end else begin
              tgt_q   <= redir_d;
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (take_redir_d) begin
            tgt_q <= redir_d;
          end
          if (!imem_busy) begin
            if (halt) begin
              state_q <= HALTED;
            end else begin
              // A redirect arriving on the completing cycle is the newest target.
              pc_q    <= take_redir_d ? redir_d : tgt_q;
              state_q <= RUN;
            end
          end
        end
        HALTED: begin
          state_q <= HALTED;
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  // IF/EX latch: flush beats stall, stall holds, completed RUN fetch loads, else bubble.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      ifex_valid_q <= 1'b0;
      ifex_instr_q <= NOP_INSTR;
      ifex_pc_q    <= 32'd0;
      ifex_pc4_q   <= 32'd0;
    end else if (state_q == HALTED || if_ex_flush) begin
      ifex_valid_q <= 1'b0;
      ifex_instr_q <= NOP_INSTR;
    end else if (if_ex_stall) begin
      ifex_valid_q <= ifex_valid_q;
    end else if (load_ok_d) begin
      ifex_valid_q <= 1'b1;
      ifex_instr_q <= imem_rdata;
      ifex_pc_q    <= pc_q;
      ifex_pc4_q   <= pc_plus4_d;
    end else begin
      ifex_valid_q <= 1'b0;
      ifex_instr_q <= NOP_INSTR;
    end
  end

endmodule

// File: tb/tb_tspp_fetch_unit.sv
// Bench for tspp_fetch_unit: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the fetch rules.
module tb_tspp_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0200;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        pc_en, npc_sel, if_ex_stall, if_ex_flush, halt;
  logic [31:0] redirect_addr;
  logic        imem_busy;
  logic [31:0] imem_rdata;
  logic        iren;
  logic [31:0] iaddr;
  logic        i_ram_busy;
  logic        ifex_valid;
  logic [31:0] ifex_instr, ifex_pc, ifex_pc4;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  logic [31:0] m_pc, m_pending, m_instr, m_ipc, m_ipc4;
  bit          m_draining, m_halted, m_valid;

  tspp_fetch_unit dut (
    .CLK(CLK), .nRST(nRST), .pc_en(pc_en), .npc_sel(npc_sel),
    .if_ex_stall(if_ex_stall), .if_ex_flush(if_ex_flush), .halt(halt),
    .redirect_addr(redirect_addr), .imem_busy(imem_busy), .imem_rdata(imem_rdata),
    .iren(iren), .iaddr(iaddr), .i_ram_busy(i_ram_busy), .ifex_valid(ifex_valid),
    .ifex_instr(ifex_instr), .ifex_pc(ifex_pc), .ifex_pc4(ifex_pc4)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock of the fetch rules, evaluated from the inputs present at the edge.
  task automatic model_edge();
    logic [31:0] aligned;
    bit          word_ok, finished;
    aligned = redirect_addr & 32'hFFFF_FFFC;
    if (!nRST) begin
      m_pc = RST_PC; m_pending = 0; m_draining = 0; m_halted = 0;
      m_valid = 0; m_instr = NOP; m_ipc = 0; m_ipc4 = 0;
      return;
    end
    if (m_halted) begin
      m_valid = 0; m_instr = NOP;
      return;
    end
    finished = !imem_busy;
    word_ok  = !m_draining && finished && !halt;
    if (if_ex_flush) begin
      m_valid = 0; m_instr = NOP;
    end else if (if_ex_stall) begin
      // hold
    end else if (word_ok) begin
      m_valid = 1; m_instr = imem_rdata; m_ipc = m_pc; m_ipc4 = m_pc + 4;
    end else begin
      m_valid = 0; m_instr = NOP;
    end
    if (finished && halt) begin
      m_halted = 1; m_draining = 0;
    end else if (m_draining) begin
      if (pc_en && npc_sel) m_pending = aligned;
      if (finished) begin
        m_pc = m_pending; m_draining = 0;
      end
    end else if (pc_en) begin
      if (!npc_sel) m_pc = m_pc + 4;
      else if (finished) m_pc = aligned;
      else begin
        m_pending = aligned; m_draining = 1;
      end
    end
  endtask

  task automatic compare_all();
    check_eq("iren", {31'd0, iren}, {31'd0, !m_halted});
    check_eq("iaddr", iaddr, m_pc);
    check_eq("i_ram_busy", {31'd0, i_ram_busy}, {31'd0, (!m_halted && imem_busy)});
    check_eq("ifex_valid", {31'd0, ifex_valid}, {31'd0, m_valid});
    check_eq("ifex_instr", ifex_instr, m_instr);
    if (m_valid) begin
      check_eq("ifex_pc", ifex_pc, m_ipc);
      check_eq("ifex_pc4", ifex_pc4, m_ipc4);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic drive(input bit en, input bit sel, input bit busy,
                       input logic [31:0] rd, input logic [31:0] ra);
    pc_en = en; npc_sel = sel; imem_busy = busy; imem_rdata = rd; redirect_addr = ra;
  endtask

  initial begin
    nRST = 0; pc_en = 0; npc_sel = 0; if_ex_stall = 0; if_ex_flush = 0; halt = 0;
    redirect_addr = 0; imem_busy = 0; imem_rdata = 0;
    m_halted = 0; m_draining = 0;

    // reset
    step();
    nRST = 1;
    check_eq("rst_iaddr", iaddr, 32'h200);
    check_eq("rst_iren", {31'd0, iren}, 32'd1);
    check_eq("rst_valid", {31'd0, ifex_valid}, 32'd0);
    check_eq("rst_instr", ifex_instr, 32'h13);

    // sequential fetch
    drive(1, 0, 0, 32'h1111_0001, 0);
    step();
    check_eq("seq_iaddr", iaddr, 32'h204);
    check_eq("seq_ifex_pc", ifex_pc, 32'h200);
    check_eq("seq_ifex_pc4", ifex_pc4, 32'h204);
    check_eq("seq_valid", {31'd0, ifex_valid}, 32'd1);

    // busy for three cycles at 0x204
    drive(0, 0, 1, 32'hBAD0_0000, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("busy_flag", {31'd0, i_ram_busy}, 32'd1);
      check_eq("busy_valid", {31'd0, ifex_valid}, 32'd0);
      check_eq("busy_iaddr", iaddr, 32'h204);
    end
    drive(1, 0, 0, 32'h00A0_0093, 0);
    step();
    check_eq("busy_instr", ifex_instr, 32'h00A0_0093);
    check_eq("busy_ifex_pc", ifex_pc, 32'h204);

    // redirect while busy at 0x208
    drive(1, 1, 1, 32'hBAD0_0001, 32'h400);
    step();
    check_eq("drain_iaddr0", iaddr, 32'h208);
    drive(0, 0, 1, 32'hBAD0_0002, 0);
    step();
    check_eq("drain_iaddr1", iaddr, 32'h208);
    drive(0, 0, 0, 32'hDEAD_BEEF, 0);
    step();
    check_eq("drain_target", iaddr, 32'h400);
    check_eq("drain_discard", {31'd0, ifex_valid}, 32'd0);

    // flush and stall together
    drive(1, 0, 0, 32'h0000_1234, 0);
    step();
    check_eq("pre_flush_valid", {31'd0, ifex_valid}, 32'd1);
    drive(0, 0, 0, 32'h0000_5678, 0);
    if_ex_flush = 1; if_ex_stall = 1;
    step();
    check_eq("flush_valid", {31'd0, ifex_valid}, 32'd0);
    check_eq("flush_instr", ifex_instr, 32'h13);
    if_ex_flush = 0; if_ex_stall = 0;

    // wrap and alignment
    drive(1, 1, 0, 32'h0, 32'hFFFF_FFFC);
    step();
    check_eq("wrap_pre", iaddr, 32'hFFFF_FFFC);
    drive(1, 0, 0, 32'h0, 0);
    step();
    check_eq("wrap_pc", iaddr, 32'h0);
    check_eq("wrap_pc4", ifex_pc4, 32'h0);
    drive(1, 1, 0, 32'h0, 32'h303);
    step();
    check_eq("align_pc", iaddr, 32'h300);

    // halt while busy
    drive(0, 0, 1, 32'h0, 0);
    halt = 1;
    step();
    check_eq("halt_busy_iren0", {31'd0, iren}, 32'd1);
    step();
    check_eq("halt_busy_iren1", {31'd0, iren}, 32'd1);
    imem_busy = 0;
    step();
    check_eq("halted_iren", {31'd0, iren}, 32'd0);
    halt = 0;
    drive(1, 0, 0, 32'h0, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("halted_iren_hold", {31'd0, iren}, 32'd0);
      check_eq("halted_valid", {31'd0, ifex_valid}, 32'd0);
    end
    nRST = 0;
    step();
    nRST = 1;
    check_eq("rerst_iaddr", iaddr, 32'h200);
    check_eq("rerst_iren", {31'd0, iren}, 32'd1);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      nRST          = ($urandom_range(0, 149) != 0);
      pc_en         = ($urandom_range(0, 3) != 0);
      npc_sel       = ($urandom_range(0, 4) == 0);
      if_ex_stall   = ($urandom_range(0, 7) == 0);
      if_ex_flush   = ($urandom_range(0, 9) == 0);
      halt          = ($urandom_range(0, 59) == 0);
      imem_busy     = ($urandom_range(0, 9) < 3);
      imem_rdata    = $urandom();
      redirect_addr = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                                   : $urandom();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
